// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Constants and helpers shared by the time keeper and the hourly chime.
//   - field_e : 2-bit encoding of the time keeper state, also driven out on
//               the 'field' port so the display can blink the field in edit.
//   - TIME_W, HOUR_MAX, MIN_MAX, SEC_MAX : widths and wrap points.
//   - wrap_inc / wrap_dec : modular step of a time field (0..max).
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int unsigned TIME_W = 6;

    localparam logic [TIME_W-1:0] HOUR_MAX = TIME_W'(23);
    localparam logic [TIME_W-1:0] MIN_MAX  = TIME_W'(59);
    localparam logic [TIME_W-1:0] SEC_MAX  = TIME_W'(59);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } field_e;

    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v >= max) ? '0 : v + TIME_W'(1);
    endfunction

    function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v == '0 || v > max) ? max : v - TIME_W'(1);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen
//   Divides clk down to a one-cycle tick every CLK_HZ cycles.
//   Parameters:
//     CLK_HZ : clk frequency in Hz (>= 2); tick period in cycles.
//   Ports:
//     clk  in  1  clock
//     rst  in  1  asynchronous active-high reset
//     en   in  1  count enable; when low the divider is held at 0
//     tick out 1  registered pulse, high in the cycle the count is CLK_HZ-1
// ---------------------------------------------------------------------------
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned      CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] PRE   = CNT_W'(CLK_HZ - 2);

    logic [CNT_W-1:0] count;

    // tick is registered one cycle ahead (count==PRE) so it is high exactly
    // while count==LAST without any decode after the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!en) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
            tick  <= (count == PRE);
        end
    end

endmodule

// File: rtl/rtc_time_keeper.sv
// ---------------------------------------------------------------------------
// rtc_time_keeper
//   24-hour hh:mm:ss counter with a button-driven set mode.
//   Parameters:
//     CLK_HZ : clk frequency in Hz (>= 2); one second = CLK_HZ cycles.
//   Configuration macro:
//     DEC_BTN_EN : adds the dec_btn port and decrement of the selected field.
//   Ports:
//     clk      in  1  system clock
//     rst      in  1  asynchronous active-high reset
//     set_mode in  1  switch level: 1 = set mode, 0 = run
//     sel_btn  in  1  button: advance the field being set
//     inc_btn  in  1  button: increment the selected field
//     dec_btn  in  1  button: decrement the selected field (DEC_BTN_EN only)
//     hour     out 6  0..23
//     min      out 6  0..59
//     sec      out 6  0..59
//     sec_tick out 1  one-cycle pulse per second while running
//     field    out 2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
// ---------------------------------------------------------------------------
module rtc_time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_mode,
    input  logic              sel_btn,
    input  logic              inc_btn,
`ifdef DEC_BTN_EN
    input  logic              dec_btn,
`endif
    output logic [TIME_W-1:0] hour,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] sec,
    output logic              sec_tick,
    output logic [1:0]        field
);

    // Input bundle: bit 0 is the set_mode level, bits 1.. are buttons.
`ifdef DEC_BTN_EN
    localparam int unsigned NB = 4;
`else
    localparam int unsigned NB = 3;
`endif

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:1] btn_prev;
    logic [NB-1:1] btn_rise;

`ifdef DEC_BTN_EN
    assign raw = {dec_btn, inc_btn, sel_btn, set_mode};
`else
    assign raw = {inc_btn, sel_btn, set_mode};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_prev <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            btn_prev <= sync2[NB-1:1];
        end
    end

    assign btn_rise = sync2[NB-1:1] & ~btn_prev;

    logic mode_lvl;
    logic sel_ev;
    logic inc_ev;
    logic dec_ev;

    assign mode_lvl = sync2[0];
    assign sel_ev   = btn_rise[1];

    // Simultaneous inc and dec cancel each other.
`ifdef DEC_BTN_EN
    assign inc_ev = btn_rise[2] & ~btn_rise[3];
    assign dec_ev = btn_rise[3] & ~btn_rise[2];
`else
    assign inc_ev = btn_rise[2];
    assign dec_ev = 1'b0;
`endif

    field_e state;
    logic   tick;
    logic   tick_en;

    // Disabling on the request (not only on the SET state) keeps a tick from
    // being issued in the cycle the FSM enters set mode, and makes the
    // divider start from 0 in the first RUN cycle after leaving it.
    assign tick_en = (state == ST_RUN) && !mode_lvl;

    sec_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            hour  <= '0;
            min   <= '0;
            sec   <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (tick) begin
                        sec <= wrap_inc(sec, SEC_MAX);
                        if (sec == SEC_MAX) begin
                            min <= wrap_inc(min, MIN_MAX);
                            if (min == MIN_MAX) begin
                                hour <= wrap_inc(hour, HOUR_MAX);
                            end
                        end
                    end
                    if (mode_lvl) begin
                        state <= ST_SET_HOUR;
                    end
                end

                default: begin
                    if (!mode_lvl) begin
                        // Leaving set mode drops any coincident button edge.
                        state <= ST_RUN;
                    end else begin
                        // Edit lands on the current field before sel moves on.
                        unique case (state)
                            ST_SET_HOUR: begin
                                if (inc_ev)      hour <= wrap_inc(hour, HOUR_MAX);
                                else if (dec_ev) hour <= wrap_dec(hour, HOUR_MAX);
                            end
                            ST_SET_MIN: begin
                                if (inc_ev)      min <= wrap_inc(min, MIN_MAX);
                                else if (dec_ev) min <= wrap_dec(min, MIN_MAX);
                            end
                            default: begin
                                if (inc_ev)      sec <= wrap_inc(sec, SEC_MAX);
                                else if (dec_ev) sec <= wrap_dec(sec, SEC_MAX);
                            end
                        endcase

                        if (sel_ev) begin
                            unique case (state)
                                ST_SET_HOUR: state <= ST_SET_MIN;
                                ST_SET_MIN:  state <= ST_SET_SEC;
                                default:     state <= ST_SET_HOUR;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign sec_tick = tick;
    assign field    = state;

endmodule

// File: tb/tb_rtc_time_keeper.sv
module tb_rtc_time_keeper;
    import clock_pkg::*;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       set_mode = 1'b0;
    logic       sel_btn  = 1'b0;
    logic       inc_btn  = 1'b0;
`ifdef DEC_BTN_EN
    logic       dec_btn  = 1'b0;
`endif
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_tick;
    logic [1:0] field;

    int errors    = 0;
    int checks    = 0;
    int bad_ticks = 0;

    typedef struct {
        int h;
        int m;
        int s;
        int f;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    rtc_time_keeper #(
        .CLK_HZ(10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_mode(set_mode),
        .sel_btn (sel_btn),
        .inc_btn (inc_btn),
`ifdef DEC_BTN_EN
        .dec_btn (dec_btn),
`endif
        .hour    (hour),
        .min     (min),
        .sec     (sec),
        .sec_tick(sec_tick),
        .field   (field)
    );

    always #5 clk = ~clk;

    // sec_tick must never be seen outside RUN.
    always @(negedge clk) begin
        if (!rst && field !== 2'd0 && sec_tick !== 1'b0) bad_ticks++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_time(input string tag, input int h, input int m, input int s, input int f);
        exp_t e;
        e.h = h; e.m = m; e.s = s; e.f = f;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic check_sb();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        chk({t, ".hour"},  hour,  e.h);
        chk({t, ".min"},   min,   e.m);
        chk({t, ".sec"},   sec,   e.s);
        chk({t, ".field"}, field, e.f);
    endtask

    // which: 0 sel, 1 inc, 2 dec
    task automatic drive(input int which, input logic v);
        case (which)
            0: sel_btn = v;
            1: inc_btn = v;
`ifdef DEC_BTN_EN
            2: dec_btn = v;
`endif
            default: ;
        endcase
    endtask

    task automatic press(input int which, input int n);
        repeat (n) begin
            drive(which, 1'b1);
            repeat (3) @(negedge clk);
            drive(which, 1'b0);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic wait_field(input string tag, input logic [1:0] tgt);
        int n = 0;
        while (field !== tgt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, field, tgt);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int first;

        // ---- 1: asynchronous reset in the middle of a count
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("pre_reset.sec", sec, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst.sec_tick", sec_tick, 0);
        expect_time("rst", 0, 0, 0, 0);
        check_sb();

        // ---- 2: 600 clk of running
        @(negedge clk);
        rst   = 1'b0;
        ticks = 0;
        first = -1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (sec_tick === 1'b1) begin
                ticks++;
                if (first < 0) first = i;
            end
        end
        chk("run.tick_count", ticks, 60);
        chk("run.first_tick", first, 9);
        expect_time("run600", 0, 1, 0, 0);
        check_sb();

        // ---- 4: set mode editing
        rst      = 1'b1;
        set_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_field("enter_set", ST_SET_HOUR);
        press(1, 25);
        expect_time("inc_hour25", 1, 0, 0, ST_SET_HOUR);
        check_sb();
        press(0, 1);
        press(1, 3);
        expect_time("inc_min3", 1, 3, 0, ST_SET_MIN);
        check_sb();
        press(0, 2);
        expect_time("sel_wrap", 1, 3, 0, ST_SET_HOUR);
        check_sb();
        repeat (30) @(negedge clk);
        expect_time("frozen", 1, 3, 0, ST_SET_HOUR);
        check_sb();
        chk("set.no_tick", bad_ticks, 0);

        // ---- 5: leave set mode, divider restart, held button, mode-wins
        set_mode = 1'b0;
        wait_field("leave_set", ST_RUN);
        chk("leave.tick0", sec_tick, 0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sec_tick === 1'b1 && first < 0) first = k;
        end
        chk("leave.first_tick", first, 9);
        expect_time("after_tick", 1, 3, 1, 0);
        check_sb();

        set_mode = 1'b1;
        wait_field("reenter_set", ST_SET_HOUR);
        inc_btn = 1'b1;
        repeat (50) @(negedge clk);
        inc_btn = 1'b0;
        repeat (4) @(negedge clk);
        expect_time("hold_inc", 2, 3, 1, ST_SET_HOUR);
        check_sb();
        set_mode = 1'b0;
        inc_btn  = 1'b1;
        wait_field("mode_fall_inc", ST_RUN);
        expect_time("mode_wins", 2, 3, 1, 0);
        check_sb();
        inc_btn = 1'b0;

        // ---- 3: preload 23:59:58 and roll over midnight
        @(negedge clk);
        rst      = 1'b1;
        set_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_field("preload_set", ST_SET_HOUR);
        press(1, 23);
        press(0, 1);
        press(1, 59);
        press(0, 1);
        press(1, 58);
        expect_time("preload", 23, 59, 58, ST_SET_SEC);
        check_sb();
        set_mode = 1'b0;
        wait_field("preload_run", ST_RUN);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("wrap.hour@%0d", k), hour, (k < 20) ? 23 : 0);
            if (k == 10) begin
                expect_time("t59", 23, 59, 59, 0);
                check_sb();
            end
        end
        expect_time("midnight", 0, 0, 0, 0);
        check_sb();

`ifdef DEC_BTN_EN
        // ---- 6: decrement
        rst      = 1'b1;
        set_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_field("dec_set", ST_SET_HOUR);
        press(0, 1);
        press(2, 1);
        expect_time("dec_min_wrap", 0, 59, 0, ST_SET_MIN);
        check_sb();
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        repeat (3) @(negedge clk);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (3) @(negedge clk);
        expect_time("inc_dec_cancel", 0, 59, 0, ST_SET_MIN);
        check_sb();
        press(2, 1);
        expect_time("dec_min", 0, 58, 0, ST_SET_MIN);
        check_sb();
        press(0, 2);
        press(2, 1);
        expect_time("dec_hour_wrap", 23, 58, 0, ST_SET_HOUR);
        check_sb();
`endif

        chk("final.no_tick_in_set", bad_ticks, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
